voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphonic voice scheduler for the DDS path.
- Accepts key press/release events from the keyboard front end and assigns each note to one of NUM_VOICES phase-accumulator channels.
- Drives each channel's 8-bit phase increment (the accumulator's key_in); an increment of 0 holds that channel silent.
- When all voices are busy, steals the oldest voice.

Parameters:
- NUM_VOICES, 4, number of phase-accumulator channels managed.
- KEY_W, 8, phase increment width; matches accumulator key_in.
- NOTE_W, 4, note code width (up to 16 keys).
- AGE_W, 3, per-voice age counter width; saturates.

Ports:
- clk_10k  in  1  DDS sample clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- evt_valid  in  1  event offered.
- evt_ready  out  1  event accepted when evt_valid && evt_ready.
- evt_on  in  1  1 = press, 0 = release.
- evt_note  in  NOTE_W  note code.
- evt_incr  in  KEY_W  phase increment for the note; used on press only.
- voice_incr  out  NUM_VOICES*KEY_W  per-voice increment; voice i occupies bits [i*KEY_W +: KEY_W].
- voice_active  out  NUM_VOICES  voice holds a note.
- voice_clr  out  NUM_VOICES  1-cycle pulse; zeroes the accumulator phase on note start.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, active-low): all voices inactive; note, incr and age = 0; voice_incr = 0; voice_clr = 0; FSM = IDLE; evt_ready = 1; busy = 0.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - evt_ready = 1.
  - On handshake: latch on/note/incr, clear scan results, go to SCAN with idx = 0.
- SCAN: one voice per cycle, idx 0..NUM_VOICES-1. Records:
  - match: lowest active voice with note == evt_note.
  - free: lowest inactive voice.
  - oldest: active voice with maximum age; ties go to the lowest index.
  - After idx = NUM_VOICES-1, go to COMMIT.
- COMMIT, press:
  - Target = match if found, else free if found, else oldest.
  - Target gets active = 1, note, incr, age = 0, and a voice_clr pulse.
  - Every other active voice ages by +1, saturating at 2^AGE_W-1.
- COMMIT, release:
  - If match found: that voice goes inactive with incr = 0, and no voice_clr pulse.
  - Otherwise no state change.
  - Ages are untouched on release.
- After COMMIT, return to IDLE.
- Latency: handshake at cycle T; voice_* outputs update at T+NUM_VOICES+1 (registered at the end of COMMIT).
  - The next event can be accepted at T+NUM_VOICES+2.
  - Throughput is one event per NUM_VOICES+2 cycles.
- voice_clr is high exactly one cycle, the cycle in which the new voice_incr first appears.
- Retrigger of an already-sounding note reuses its voice, updates incr and pulses voice_clr. No duplicate voice is created.
- Steal: the old note on the stolen voice is discarded silently. A later release for the old note finds no match and is a no-op.
- evt_incr = 0 on press: allocated normally; the voice is active but silent.
- Event inputs are sampled only at the handshake; changes during SCAN/COMMIT are ignored.
- Reset mid-operation: immediate return to reset state; the in-flight event is lost.

Optional Feature:
- Macro: VOICE_ALLOC_SUSTAIN_EN.
- When defined:
  - Adds input port sustain (1 bit) and a per-voice held bit.
  - A release while sustain = 1 sets held on the matched voice; the voice stays active.
  - On a sustain falling edge detected in IDLE, all held voices go inactive in one cycle (incr = 0, held = 0).
  - During that cycle evt_ready = 0.
  - A press that retriggers a held voice clears its held bit.
- When undefined: no sustain port, no held state; releases take effect immediately.

Decomposition:
- Package dds_voice_pkg holds:
  - state_t enum {IDLE, SCAN, COMMIT}.
  - voice_t struct {active, held, note, incr, age}.
  - Default constants for KEY_W, NOTE_W, AGE_W.
  - Function age_inc() implementing the saturating increment.
- Sub-module voice_slot: one voice register.
  - Inputs: load, release, age_tick, sustain controls.
  - Outputs: its voice_t.
  - Instantiated NUM_VOICES times by generate.
- The allocator owns the FSM, scan index and scan results.

Test Plan:
- Reset: assert rst_n = 0 mid-SCAN -> all outputs 0, evt_ready = 1 immediately, no voice_clr.
- Press note 3 with incr 8'h10 from reset -> voice 0 gets incr 8'h10 at T+5 with a 1-cycle voice_clr[0]; next accept at T+6.
- Press notes 1,2,3,4, then press note 5 with incr 8'h22 -> voice 0 (age 3, oldest) is stolen and shows 8'h22; release of note 1 afterwards -> no change.
- Press note 2 (incr 8'h08), press note 2 again (incr 8'h09) -> same voice, incr 8'h09, second voice_clr pulse; only one voice active.
- Release of a note never pressed -> outputs unchanged; release of an active note -> voice_active bit clears and its incr = 0 after 6 cycles.
- With VOICE_ALLOC_SUSTAIN_EN: sustain = 1, press/release note 6 -> voice stays active; sustain falls -> voice inactive in one cycle, evt_ready low for that cycle.

Source files
------------

// File: rtl/dds_voice_pkg.sv
// Shared types and helpers for the DDS voice allocator: FSM states, the per-voice
// register record and the saturating age increment.
package dds_voice_pkg;

  localparam int KEY_W_DEF  = 8;
  localparam int NOTE_W_DEF = 4;
  localparam int AGE_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  typedef struct packed {
    logic                  active;
    logic                  held;
    logic [NOTE_W_DEF-1:0] note;
    logic [KEY_W_DEF-1:0]  incr;
    logic [AGE_W_DEF-1:0]  age;
  } voice_t;

  function automatic logic [AGE_W_DEF-1:0] age_inc(input logic [AGE_W_DEF-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice register of the allocator. Loads a new note, releases, holds under
// sustain, flushes held notes and ages while active.
module voice_slot
  import dds_voice_pkg::*;
(
  input  logic                  clk_10k,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [NOTE_W_DEF-1:0] load_note,
  input  logic [KEY_W_DEF-1:0]  load_incr,
  input  logic                  rel,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  age_tick,
  output voice_t                voice,
  output logic                  clr
);

  // The clear pulse is registered alongside the load so it lines up with the new incr.
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      voice <= '0;
      clr   <= 1'b0;
    end else begin
      clr <= load;
      if (load) begin
        voice <= '{active: 1'b1, held: 1'b0, note: load_note, incr: load_incr, age: '0};
      end else if (rel || (flush && voice.held)) begin
        voice.active <= 1'b0;
        voice.held   <= 1'b0;
        voice.incr   <= '0;
      end else if (hold) begin
        voice.held <= 1'b1;
      end else if (age_tick && voice.active) begin
        voice.age <= age_inc(voice.age);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans the voices one per cycle and then commits a
// press (match, free or oldest) or a release. Optional sustain via VOICE_ALLOC_SUSTAIN_EN.
module voice_allocator
  import dds_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int AGE_W      = AGE_W_DEF
) (
  input  logic                        clk_10k,
  input  logic                        rst_n,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic                        sustain,
`endif
  input  logic                        evt_valid,
  output logic                        evt_ready,
  input  logic                        evt_on,
  input  logic [NOTE_W-1:0]           evt_note,
  input  logic [KEY_W-1:0]            evt_incr,
  output logic [NUM_VOICES*KEY_W-1:0] voice_incr,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES-1:0]       voice_clr,
  output logic                        busy
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;
  logic [KEY_W-1:0]  ev_incr;
  logic              match_found, free_found, old_found;
  logic [IDX_W-1:0]  match_idx, free_idx, old_idx, target;
  logic [AGE_W-1:0]  old_age;
  voice_t            slots [NUM_VOICES];
  voice_t            cur;
  logic [NUM_VOICES-1:0] load, rel, hold, age_tick;
  logic              flush;
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic              ev_sus;
  logic              sustain_q;
`endif

  assign cur  = slots[idx];
  assign busy = (state != IDLE);

  // Event latch and scan bookkeeping; the scan results are only meaningful in COMMIT.
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      ev_on       <= 1'b0;
      ev_note     <= '0;
      ev_incr     <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      ev_sus      <= 1'b0;
      sustain_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
          sustain_q <= sustain;
`endif
          if (evt_valid && evt_ready) begin
            ev_on       <= evt_on;
            ev_note     <= evt_note;
            ev_incr     <= evt_incr;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            idx         <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
            ev_sus      <= sustain;
`endif
          end
        end
        SCAN: begin
          if (cur.active && (cur.note == ev_note) && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!cur.active && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (cur.active && (!old_found || (cur.age > old_age))) begin
            old_found <= 1'b1;
            old_idx   <= idx;
            old_age   <= cur.age;
          end
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (match_found)     target = match_idx;
    else if (free_found) target = free_idx;
    else                 target = old_idx;
  end

  always_comb begin
    state_nxt = state;
    evt_ready = 1'b0;
    load      = '0;
    rel       = '0;
    hold      = '0;
    age_tick  = '0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
        flush = sustain_q && !sustain;
`endif
        evt_ready = !flush;
        if (evt_valid && evt_ready) state_nxt = SCAN;
      end
      SCAN: begin
        if (idx == LAST_IDX) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
        if (ev_on) begin
          load[target] = 1'b1;
          age_tick     = ~load;
        end else if (match_found) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
          if (ev_sus) hold[match_idx] = 1'b1;
          else        rel[match_idx]  = 1'b1;
`else
          rel[match_idx] = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot u_slot (
      .clk_10k   (clk_10k),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_note (ev_note),
      .load_incr (ev_incr),
      .rel       (rel[i]),
      .hold      (hold[i]),
      .flush     (flush),
      .age_tick  (age_tick[i]),
      .voice     (slots[i]),
      .clr       (voice_clr[i])
    );
    assign voice_incr[i*KEY_W +: KEY_W] = slots[i].incr;
    assign voice_active[i]              = slots[i].active;
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a behavioural voice model predicts each
// commit, and a monitor compares when busy drops. Sustain checks under VOICE_ALLOC_SUSTAIN_EN.
module tb_voice_allocator;

  localparam int NV = 4;

  logic          clk_10k = 1'b0;
  logic          rst_n = 1'b0;
  logic          sustain = 1'b0;
  logic          evt_valid = 1'b0;
  logic          evt_ready;
  logic          evt_on = 1'b0;
  logic [3:0]    evt_note = '0;
  logic [7:0]    evt_incr = '0;
  logic [31:0]   voice_incr;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] voice_clr;
  logic          busy;

  typedef struct {
    logic [NV-1:0] act;
    logic [31:0]   incr;
    logic [NV-1:0] clr;
    int            hs;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_hs = 0;
  bit   back_to_back = 0;

  bit       m_active [NV];
  bit       m_held   [NV];
  int       m_note   [NV];
  logic [7:0] m_incr [NV];
  int       m_age    [NV];

  voice_allocator dut (
`ifdef VOICE_ALLOC_SUSTAIN_EN
    .sustain      (sustain),
`endif
    .clk_10k      (clk_10k),
    .rst_n        (rst_n),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_on       (evt_on),
    .evt_note     (evt_note),
    .evt_incr     (evt_incr),
    .voice_incr   (voice_incr),
    .voice_active (voice_active),
    .voice_clr    (voice_clr),
    .busy         (busy)
  );

  always #50 clk_10k = ~clk_10k;
  always @(posedge clk_10k) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic failNow(input string name);
    n_checks++;
    $display("[TB] FAIL %s: got timeout/unexpected event expected normal progress (cycle %0d)", name, cyc);
  endtask

  function automatic logic [NV-1:0] modelActive();
    logic [NV-1:0] r = '0;
    for (int i = 0; i < NV; i++) r[i] = m_active[i];
    return r;
  endfunction

  function automatic logic [31:0] modelIncr();
    logic [31:0] r = '0;
    for (int i = 0; i < NV; i++) r[i*8 +: 8] = m_incr[i];
    return r;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NV; i++) begin
      m_active[i] = 0; m_held[i] = 0; m_note[i] = 0; m_incr[i] = '0; m_age[i] = 0;
    end
  endfunction

  // Reference behaviour: returns the voice_clr pattern the event should produce.
  function automatic logic [NV-1:0] modelEvent(input bit on, input int note, input logic [7:0] incr, input bit sus);
    int match = -1;
    int t = -1;
    logic [NV-1:0] clr = '0;
    for (int i = 0; i < NV; i++)
      if (match < 0 && m_active[i] && m_note[i] == note) match = i;
    if (on) begin
      t = match;
      if (t < 0)
        for (int i = 0; i < NV; i++) if (t < 0 && !m_active[i]) t = i;
      if (t < 0)
        for (int i = 0; i < NV; i++) if (t < 0 || m_age[i] > m_age[t]) t = i;
      for (int i = 0; i < NV; i++)
        if (i != t && m_active[i]) m_age[i] = (m_age[i] >= 7) ? 7 : m_age[i] + 1;
      m_active[t] = 1; m_held[t] = 0; m_note[t] = note; m_incr[t] = incr; m_age[t] = 0;
      clr[t] = 1'b1;
    end else if (match >= 0) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
      if (sus) m_held[match] = 1;
      else begin m_active[match] = 0; m_incr[match] = '0; m_held[match] = 0; end
`else
      if (sus || !sus) begin m_active[match] = 0; m_incr[match] = '0; m_held[match] = 0; end
`endif
    end
    return clr;
  endfunction

  task automatic applyStimulus(input bit on, input logic [3:0] note, input logic [7:0] incr);
    int waited = 0;
    int hs;
    exp_t e;
    @(negedge clk_10k);
    evt_valid = 1'b1; evt_on = on; evt_note = note; evt_incr = incr;
    while (!evt_ready && waited < 20) begin
      @(negedge clk_10k);
      waited++;
    end
    if (!evt_ready) begin
      failNow("handshake_timeout");
      evt_valid = 1'b0;
      return;
    end
    @(posedge clk_10k);
    #1;
    hs = cyc;
    evt_valid = 1'b0;
    evt_on = 1'($urandom); evt_note = 4'($urandom); evt_incr = 8'($urandom);
    if (back_to_back) checkOutput("throughput_gap", 32'(hs - last_hs), 32'd6);
    last_hs = hs;
    back_to_back = 1;
    e.clr  = modelEvent(on, int'(note), incr, sustain);
    e.act  = modelActive();
    e.incr = modelIncr();
    e.hs   = hs;
    sb.push_back(e);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    evt_valid = 1'b0;
    #1;
    sb.delete();
    modelReset();
    back_to_back = 0;
    checkOutput("reset_active", 32'(voice_active), 32'd0);
    checkOutput("reset_incr", voice_incr, 32'd0);
    checkOutput("reset_clr", 32'(voice_clr), 32'd0);
    checkOutput("reset_ready", 32'(evt_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk_10k);
    rst_n = 1'b1;
  endtask

  task automatic waitIdle();
    repeat (7) @(negedge clk_10k);
    back_to_back = 0;
  endtask

  // Monitor: a falling busy marks a commit whose result is now on the outputs.
  initial begin
    bit prev_busy;
    bit clr_chk;
    exp_t e;
    prev_busy = 0;
    clr_chk = 0;
    forever begin
      @(negedge clk_10k);
      if (!rst_n) begin
        prev_busy = 0;
        clr_chk = 0;
      end else begin
        if (clr_chk) begin
          checkOutput("clr_one_cycle", 32'(voice_clr), 32'd0);
          clr_chk = 0;
        end
        if (prev_busy && !busy) begin
          if (sb.size() == 0) failNow("unexpected_commit");
          else begin
            e = sb.pop_front();
            checkOutput("commit_active", 32'(voice_active), 32'(e.act));
            checkOutput("commit_incr", voice_incr, e.incr);
            checkOutput("commit_clr", 32'(voice_clr), 32'(e.clr));
            checkOutput("commit_latency", 32'(cyc - e.hs), 32'd5);
            clr_chk = (e.clr != '0);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #(100 * 50000);
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetDut();

    applyStimulus(1, 4'd3, 8'h10);
    repeat (6) @(negedge clk_10k);
    checkOutput("first_press_v0", 32'(voice_incr[7:0]), 32'h10);
    waitIdle();

    resetDut();
    applyStimulus(1, 4'd1, 8'h01);
    applyStimulus(1, 4'd2, 8'h02);
    applyStimulus(1, 4'd3, 8'h03);
    applyStimulus(1, 4'd4, 8'h04);
    applyStimulus(1, 4'd5, 8'h22);
    repeat (6) @(negedge clk_10k);
    checkOutput("steal_v0", 32'(voice_incr[7:0]), 32'h22);
    back_to_back = 0;
    applyStimulus(0, 4'd1, 8'h00);
    waitIdle();

    resetDut();
    applyStimulus(1, 4'd2, 8'h08);
    applyStimulus(1, 4'd2, 8'h09);
    applyStimulus(0, 4'd9, 8'h00);
    repeat (6) @(negedge clk_10k);
    checkOutput("retrigger_single", 32'(voice_active), 32'h1);
    back_to_back = 0;
    applyStimulus(0, 4'd2, 8'h00);
    waitIdle();

    // Populate voices, then reset in the middle of a scan.
    applyStimulus(1, 4'd7, 8'h40);
    applyStimulus(1, 4'd8, 8'h41);
    waitIdle();
    applyStimulus(1, 4'd9, 8'h42);
    @(posedge clk_10k);
    #1;
    resetDut();

`ifdef VOICE_ALLOC_SUSTAIN_EN
    sustain = 1'b1;
    applyStimulus(1, 4'd6, 8'h30);
    applyStimulus(0, 4'd6, 8'h00);
    waitIdle();
    checkOutput("sustain_held", 32'(voice_active), 32'h1);
    sustain = 1'b0;
    #1;
    checkOutput("flush_ready_low", 32'(evt_ready), 32'd0);
    for (int i = 0; i < NV; i++)
      if (m_held[i]) begin m_active[i] = 0; m_incr[i] = '0; m_held[i] = 0; end
    @(posedge clk_10k);
    #1;
    checkOutput("flush_active", 32'(voice_active), 32'(modelActive()));
    checkOutput("flush_incr", voice_incr, modelIncr());
    checkOutput("flush_ready_back", 32'(evt_ready), 32'd1);
    waitIdle();
`endif

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 8)) @(negedge clk_10k);
        back_to_back = 0;
      end
      applyStimulus($urandom_range(0, 2) != 0, 4'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
    end

    waitIdle();
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
